// File: rtl/occupancy_controller_pkg.sv
// Shared types and defaults for the room occupancy controller and its sensor filters.
package occupancy_controller_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    S1_FIRST   = 2'd1,
    S2_FIRST   = 2'd2,
    WAIT_CLEAR = 2'd3
  } occ_state_e;

  localparam int unsigned DEF_CNT_W     = 8;
  localparam int unsigned DEF_MAX_OCC   = 50;
  localparam int unsigned DEF_DEBOUNCE  = 4;
  localparam int unsigned DEF_SEQ_TMO   = 32;
  localparam int unsigned DEF_OFF_DELAY = 16;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/occupancy_controller_ir_debounce.sv
// Two-flop synchroniser followed by a stability filter for one raw IR beam input.
module ir_debounce
  import occupancy_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic raw_i,
  output logic filt_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the synced level agrees with the filtered level restarts the run.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/occupancy_controller.sv
// Decodes IR beam order into entries/exits, keeps a saturating occupancy count and drives the light.
module occupancy_controller
  import occupancy_controller_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned MAX_OCC   = DEF_MAX_OCC,
  parameter int unsigned DEBOUNCE  = DEF_DEBOUNCE,
  parameter int unsigned SEQ_TMO   = DEF_SEQ_TMO,
  parameter int unsigned OFF_DELAY = DEF_OFF_DELAY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ir_sensor1,
  input  logic             ir_sensor2,
  output logic [CNT_W-1:0] curr_visitor,
  output logic             entry_pulse,
  output logic             exit_pulse,
  output logic             room_full,
  output logic             light_on,
  output logic             seq_err
);

  localparam int unsigned TW = cnt_width(SEQ_TMO);
  localparam int unsigned OW = cnt_width(OFF_DELAY);

  logic             f1, f2;
  occ_state_e       state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             entry_ev_q, entry_ev_d;
  logic             exit_ev_q, exit_ev_d;
  logic             seq_abort;
  logic [CNT_W-1:0] count_q, count_d;
  logic             entry_pulse_q, entry_pulse_d;
  logic             exit_pulse_q, exit_pulse_d;
  logic             err_q, err_d;
  logic             light_q, light_d;
  logic [OW-1:0]    off_q, off_d;

  ir_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb1 (
    .clk    (clk),
    .rst_ni (reset),
    .raw_i  (ir_sensor1),
    .filt_o (f1)
  );

  ir_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb2 (
    .clk    (clk),
    .rst_ni (reset),
    .raw_i  (ir_sensor2),
    .filt_o (f2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      entry_ev_q    <= 1'b0;
      exit_ev_q     <= 1'b0;
      count_q       <= '0;
      entry_pulse_q <= 1'b0;
      exit_pulse_q  <= 1'b0;
      err_q         <= 1'b0;
      light_q       <= 1'b0;
      off_q         <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      entry_ev_q    <= entry_ev_d;
      exit_ev_q     <= exit_ev_d;
      count_q       <= count_d;
      entry_pulse_q <= entry_pulse_d;
      exit_pulse_q  <= exit_pulse_d;
      err_q         <= err_d;
      light_q       <= light_d;
      off_q         <= off_d;
    end
  end

  // Timer defaults to zero so it restarts on every state change and only runs while waiting.
  always_comb begin
    state_d    = state_q;
    tmr_d      = '0;
    entry_ev_d = 1'b0;
    exit_ev_d  = 1'b0;
    seq_abort  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (f1 && !f2) begin
          state_d = S1_FIRST;
        end else if (f2 && !f1) begin
          state_d = S2_FIRST;
        end else if (f1 && f2) begin
          state_d = WAIT_CLEAR;
        end
      end
      S1_FIRST: begin
        if (f2) begin
          state_d    = WAIT_CLEAR;
          entry_ev_d = 1'b1;
        end else if (!f1 || (tmr_q == TW'(SEQ_TMO))) begin
          state_d   = IDLE;
          seq_abort = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S2_FIRST: begin
        if (f1) begin
          state_d   = WAIT_CLEAR;
          exit_ev_d = 1'b1;
        end else if (!f2 || (tmr_q == TW'(SEQ_TMO))) begin
          state_d   = IDLE;
          seq_abort = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_CLEAR: begin
        if (!f1 && !f2) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d       = count_q;
    entry_pulse_d = 1'b0;
    exit_pulse_d  = 1'b0;
    err_d         = err_q | seq_abort;
    if (entry_ev_q) begin
      if (count_q < CNT_W'(MAX_OCC)) begin
        count_d       = count_q + 1'b1;
        entry_pulse_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (exit_ev_q) begin
      if (count_q != '0) begin
        count_d      = count_q - 1'b1;
        exit_pulse_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Light follows the next count so it rises with the first entry; the off-delay starts on the drop to zero.
  always_comb begin
    light_d = light_q;
    off_d   = off_q;
    if (count_d != '0) begin
      light_d = 1'b1;
      off_d   = '0;
    end else if (count_q != '0) begin
      off_d   = OW'(OFF_DELAY);
      light_d = (OFF_DELAY != 0);
    end else if (off_q != '0) begin
      off_d = off_q - 1'b1;
      if (off_q == OW'(1)) begin
        light_d = 1'b0;
      end
    end
  end

  assign curr_visitor = count_q;
  assign entry_pulse  = entry_pulse_q;
  assign exit_pulse   = exit_pulse_q;
  assign room_full    = (count_q == CNT_W'(MAX_OCC));
  assign light_on     = light_q;
  assign seq_err      = err_q;

endmodule
